// File: rtl/intr_ctrl_if.sv
// Register port of the interrupt controller: single-cycle write strobe, combinational read.
interface intr_ctrl_if;
  // bus_we qualifies bus_addr/bus_wdata for exactly one clock edge and is always accepted
  // (no ready/wait states); bus_rdata follows bus_addr combinationally.
  logic       bus_we;
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;

  modport master (output bus_we, output bus_addr, output bus_wdata, input bus_rdata);
  modport slave  (input bus_we, input bus_addr, input bus_wdata, output bus_rdata);
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller for the jacaranda-8 core: edge-latched pending bits, fixed priority,
// single-level request/service handshake released by the core's ret.
module intr_ctrl #(
  parameter int N_SRC = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cpu_ret,
  intr_ctrl_if.slave       bus,
  output logic             int_req,
  output logic [7:0]       int_en,
  output logic [7:0]       int_vec,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [N_SRC-1:0] s1, s2, s3;
  logic [N_SRC-1:0] rise, pend, pend_nx, mask, cand, clr;
  logic             gie;
  logic [7:0]       vbase;
  logic [2:0]       win_idx, cand_idx;
  logic             load_req, ack;
  logic             wr_ctrl, wr_mask, wr_pend, wr_vbase;
  logic [7:0]       mask_rd, pend_rd;

  assign wr_ctrl  = bus.bus_we && (bus.bus_addr == 2'd0);
  assign wr_mask  = bus.bus_we && (bus.bus_addr == 2'd1);
  assign wr_pend  = bus.bus_we && (bus.bus_addr == 2'd2);
  assign wr_vbase = bus.bus_we && (bus.bus_addr == 2'd3);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign cand = pend & mask;

  // Scan from the top so the lowest set index is the last assignment and wins.
  always_comb begin
    cand_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) cand_idx = 3'(i);
    end
  end

  always_comb begin
    state_nx = state;
    load_req = 1'b0;
    ack      = 1'b0;
    case (state)
      S_IDLE: begin
        if (gie && (cand != '0)) begin
          state_nx = S_REQ;
          load_req = 1'b1;
        end
      end
      S_REQ: begin
        if (gie) begin
          ack      = 1'b1;
          state_nx = S_SERVICE;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (cpu_ret) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A rise arriving in the same cycle as an ack or W1C re-sets the bit.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = (wr_pend && bus.bus_wdata[i]) || (ack && (win_idx == 3'(i)));
    end
  end

  assign pend_nx = (pend & ~clr) | rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pend    <= '0;
      mask    <= '0;
      gie     <= 1'b0;
      vbase   <= 8'h00;
      win_idx <= 3'd0;
      int_vec <= 8'h00;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
      if (wr_ctrl)  gie   <= bus.bus_wdata[0];
      if (wr_mask)  mask  <= bus.bus_wdata[N_SRC-1:0];
      if (wr_vbase) vbase <= bus.bus_wdata;
      if (load_req) begin
        win_idx <= cand_idx;
        int_vec <= vbase + {3'b000, cand_idx, 2'b00};
      end
    end
  end

  assign int_req   = (state == S_REQ) && gie;
  assign int_en    = {7'b0, gie};
  assign dbg_state = state;

  always_comb begin
    mask_rd = 8'h00;
    pend_rd = 8'h00;
    mask_rd[N_SRC-1:0] = mask;
    pend_rd[N_SRC-1:0] = pend;
    case (bus.bus_addr)
      2'd0:    bus.bus_rdata = {6'b0, (state != S_IDLE), gie};
      2'd1:    bus.bus_rdata = mask_rd;
      2'd2:    bus.bus_rdata = pend_rd;
      default: bus.bus_rdata = vbase;
    endcase
  end

endmodule
